// File: rtl/ripple_ctrl_if.sv
// Button, run and LED-stage control signals for the ripple controller.
// The master side owns the raw buttons and run. The slave side is the
// controller, which returns the tick, direction and speed index.
interface ripple_ctrl_if;
   logic       btn_dir;
   logic       btn_speed;
   logic       run;
   logic       shift_tick;
   logic       dir;
   logic [1:0] speed_sel;

   modport master (
      output btn_dir,
      output btn_speed,
      output run,
      input  shift_tick,
      input  dir,
      input  speed_sel
   );

   modport slave (
      input  btn_dir,
      input  btn_speed,
      input  run,
      output shift_tick,
      output dir,
      output speed_sel
   );
endinterface

// File: rtl/ripple_ctrl.sv
// Upstream control stage for the 8-bit rippling-LED shifter.
// Each raw button is synchronised, debounced and edge-detected. A dir press
// toggles the ripple direction. A speed press steps the rate index and
// restarts the tick counter. shift_tick is a one-cycle pulse every
// BASE_PERIOD << speed_sel cycles while run is high.
module ripple_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BASE_PERIOD     = 5,
   parameter int CNT_W           = 8
) (
   input  logic         clk,
   input  logic         reset,
   ripple_ctrl_if.slave bus
);

   // The debounce counter only ever has to reach DEBOUNCE_CYCLES-1.
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 is the direction button. Bit 1 is the speed button.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {bus.btn_speed, bus.btn_dir};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic            s1_q, s1_d;
         logic            s2_q, s2_d;
         logic            db_q, db_d;
         logic            db_dly_q, db_dly_d;
         logic [DB_W-1:0] db_cnt_q, db_cnt_d;

         // Synchroniser shift, then debounce: the synchronised level must
         // disagree with the debounced state for DEBOUNCE_CYCLES
         // consecutive cycles before the debounced state follows it.
         always_comb begin
            s1_d     = btn_raw[gi];
            s2_d     = s1_q;
            db_dly_d = db_q;
            db_d     = db_q;
            db_cnt_d = db_cnt_q;
            if (s2_q == db_q) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               db_d     = s2_q;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         // Button state registers. Reset forces a held button to be
         // debounced again from scratch.
         always_ff @(posedge clk) begin
            if (reset) begin
               s1_q     <= 1'b0;
               s2_q     <= 1'b0;
               db_q     <= 1'b0;
               db_dly_q <= 1'b0;
               db_cnt_q <= '0;
            end else begin
               s1_q     <= s1_d;
               s2_q     <= s2_d;
               db_q     <= db_d;
               db_dly_q <= db_dly_d;
               db_cnt_q <= db_cnt_d;
            end
         end

         // A press is high for one cycle per debounced rising edge.
         // Releases are ignored.
         assign press[gi] = db_q & ~db_dly_q;
      end
   endgenerate

   logic             dir_q, dir_d;
   logic [1:0]       speed_sel_q, speed_sel_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] period_last;

   assign period      = CNT_W'(BASE_PERIOD) << speed_sel_q;
   assign period_last = period - 1'b1;

   // Control state: apply presses and advance the tick counter. A speed
   // press wins over a due tick so the new rate starts from a clean count.
   always_comb begin
      dir_d       = dir_q ^ press[0];
      speed_sel_d = speed_sel_q + {1'b0, press[1]};
      tick_cnt_d  = tick_cnt_q;
      tick_d      = 1'b0;
      if (press[1]) begin
         tick_cnt_d = '0;
      end else if (bus.run) begin
         if (tick_cnt_q == period_last) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
   end

   // Control registers. All outputs come straight from these flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q       <= 1'b0;
         speed_sel_q <= 2'd0;
         tick_cnt_q  <= '0;
         tick_q      <= 1'b0;
      end else begin
         dir_q       <= dir_d;
         speed_sel_q <= speed_sel_d;
         tick_cnt_q  <= tick_cnt_d;
         tick_q      <= tick_d;
      end
   end

   assign bus.shift_tick = tick_q;
   assign bus.dir        = dir_q;
   assign bus.speed_sel  = speed_sel_q;

endmodule

// File: tb/tb_ripple_ctrl.sv
// Self-checking bench for ripple_ctrl. It uses default parameters.
// A behavioural model predicts tick, dir and speed_sel on every cycle.
// Directed tests pin the model with hand-computed edge numbers and periods.
module tb_ripple_ctrl;
   localparam int D    = 4;
   localparam int BASE = 5;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ripple_ctrl_if bus ();

   ripple_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .BASE_PERIOD    (BASE),
      .CNT_W          (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;
   bit chk_en   = 1'b0;

   always @(posedge clk) cyc_n++;

   // Behavioural model. The debouncer sees the raw level from two edges
   // earlier. A debounced level flips once its last D synchronised samples
   // all disagree with it. Ticks fall on every P-th running edge since the
   // last restart.
   bit          m_raw_d1 [2];
   bit          m_raw_d2 [2];
   logic [31:0] m_hist   [2];
   bit          m_db     [2];
   bit          m_db_prev[2];
   bit          m_dir;
   int          m_speed;
   int          m_acc;
   bit          m_tick;

   always @(posedge clk) begin
      bit pr [2];
      bit raw [2];
      logic [31:0] mask;
      mask   = (32'd1 << D) - 32'd1;
      raw[0] = bus.btn_dir;
      raw[1] = bus.btn_speed;
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_raw_d1[i]  = 1'b0;
            m_raw_d2[i]  = 1'b0;
            m_hist[i]    = '0;
            m_db[i]      = 1'b0;
            m_db_prev[i] = 1'b0;
         end
         m_dir   = 1'b0;
         m_speed = 0;
         m_acc   = 0;
         m_tick  = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            pr[i]        = m_db[i] && !m_db_prev[i];
            m_db_prev[i] = m_db[i];
            m_hist[i]    = {m_hist[i][30:0], m_raw_d2[i]};
            if (m_db[i] && ((m_hist[i] & mask) == 32'd0))
               m_db[i] = 1'b0;
            else if (!m_db[i] && ((m_hist[i] & mask) == mask))
               m_db[i] = 1'b1;
            m_raw_d2[i] = m_raw_d1[i];
            m_raw_d1[i] = raw[i];
         end
         if (pr[0]) m_dir = !m_dir;
         if (pr[1]) begin
            m_speed = (m_speed + 1) % 4;
            m_acc   = 0;
            m_tick  = 1'b0;
         end else if (bus.run) begin
            m_acc++;
            m_tick = ((m_acc % (BASE << m_speed)) == 0);
         end else begin
            m_tick = 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, plus event logs for the
   // directed tests.
   int   tick_log[$];
   int   dir_edge = -1;
   int   sp_edge  = -1;
   int   dir_toggles = 0;
   logic prev_dir = 1'b0;
   logic [1:0] prev_sp = 2'd0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic [1:0] m_sp;
         m_sp = m_speed[1:0];
         checks++;
         if (bus.shift_tick !== m_tick || bus.dir !== m_dir || bus.speed_sel !== m_sp) begin
            failures++;
            $display("FAIL model cyc=%0d tick=%b exp=%b dir=%b exp=%b speed=%0d exp=%0d",
                     cyc_n, bus.shift_tick, m_tick, bus.dir, m_dir, bus.speed_sel, m_sp);
         end
         if (bus.shift_tick === 1'b1) tick_log.push_back(cyc_n);
         if (bus.dir !== prev_dir) begin
            dir_edge = cyc_n;
            dir_toggles++;
         end
         if (bus.speed_sel !== prev_sp) sp_edge = cyc_n;
         prev_dir = bus.dir;
         prev_sp  = bus.speed_sel;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_ticks(input int n, input int budget);
      for (int w = 0; w < budget && tick_log.size() < n; w++) step(1);
      chk("tick_wait_budget", (tick_log.size() >= n) ? 1 : 0, 1);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog cyc=%0d expected=finish", cyc_n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, e0, re, exp_p;
      reset         = 1'b1;
      bus.btn_dir   = 1'b0;
      bus.btn_speed = 1'b0;
      bus.run       = 1'b0;
      step(1);
      chk_en = 1'b1;
      step(1);

      // Test 1: free-running ticks at the base period.
      chk("reset_tick", bus.shift_tick, 0);
      chk("reset_dir", bus.dir, 0);
      chk("reset_speed", bus.speed_sel, 0);
      reset   = 1'b0;
      bus.run = 1'b1;
      rel     = cyc_n;
      tick_log.delete();
      step(28);
      chk("t1_tick_count", tick_log.size(), 5);
      for (int i = 0; i < tick_log.size() && i < 5; i++)
         chk("t1_tick_edge", tick_log[i] - rel, BASE * (i + 1));
      chk("t1_dir", bus.dir, 0);
      chk("t1_speed", bus.speed_sel, 0);

      // Test 2: two clean direction presses.
      for (int k = 0; k < 2; k++) begin
         tick_log.delete();
         e0          = cyc_n + 1;
         bus.btn_dir = 1'b1;
         step(10);
         bus.btn_dir = 1'b0;
         step(10);
         chk("t2_dir_edge", dir_edge - e0, 6);
         chk("t2_dir_value", bus.dir, (k == 0) ? 1 : 0);
         for (int i = 1; i < tick_log.size(); i++)
            chk("t2_tick_spacing", tick_log[i] - tick_log[i-1], BASE);
      end

      // Test 3: a bouncing press is rejected, then a clean hold toggles once.
      dir_toggles = 0;
      bus.btn_dir = 1'b1; step(2);
      bus.btn_dir = 1'b0; step(1);
      bus.btn_dir = 1'b1; step(2);
      bus.btn_dir = 1'b0; step(10);
      chk("t3_bounce_toggles", dir_toggles, 0);
      chk("t3_bounce_dir", bus.dir, 0);
      bus.btn_dir = 1'b1; step(6);
      bus.btn_dir = 1'b0; step(12);
      chk("t3_hold_toggles", dir_toggles, 1);
      chk("t3_hold_dir", bus.dir, 1);

      // Test 4: four speed presses step the rate 1, 2, 3, 0.
      for (int k = 0; k < 4; k++) begin
         exp_p         = BASE << ((k + 1) % 4);
         e0            = cyc_n + 1;
         bus.btn_speed = 1'b1;
         step(6);
         bus.btn_speed = 1'b0;
         tick_log.delete();
         step(1);
         chk("t4_speed", bus.speed_sel, (k + 1) % 4);
         chk("t4_speed_edge", sp_edge - e0, 6);
         wait_ticks(2, 2 * exp_p + 10);
         if (tick_log.size() >= 2) begin
            chk("t4_first_tick", tick_log[0] - sp_edge, exp_p);
            chk("t4_period", tick_log[1] - tick_log[0], exp_p);
         end
         step(20);
      end

      // Test 5: freeze at count 3, then resume from the held count.
      tick_log.delete();
      wait_ticks(1, 20);
      step(3);
      bus.run = 1'b0;
      tick_log.delete();
      step(7);
      chk("t5_frozen_ticks", tick_log.size(), 0);
      bus.run = 1'b1;
      re      = cyc_n;
      step(4);
      chk("t5_resume_ticks", (tick_log.size() >= 1) ? 1 : 0, 1);
      if (tick_log.size() >= 1) chk("t5_resume_edge", tick_log[0] - re, 2);

      // Test 6: a simultaneous press, then reset in mid-period.
      e0            = cyc_n + 1;
      bus.btn_dir   = 1'b1;
      bus.btn_speed = 1'b1;
      step(6);
      bus.btn_dir   = 1'b0;
      bus.btn_speed = 1'b0;
      step(1);
      chk("t6_same_edge", dir_edge - sp_edge, 0);
      chk("t6_press_edge", dir_edge - e0, 6);
      chk("t6_dir", bus.dir, 0);
      chk("t6_speed", bus.speed_sel, 1);
      step(3);
      reset = 1'b1;
      step(2);
      chk("t6_rst_tick", bus.shift_tick, 0);
      chk("t6_rst_dir", bus.dir, 0);
      chk("t6_rst_speed", bus.speed_sel, 0);
      reset = 1'b0;
      rel   = cyc_n;
      tick_log.delete();
      step(6);
      chk("t6_post_rst_ticks", (tick_log.size() >= 1) ? 1 : 0, 1);
      if (tick_log.size() >= 1) chk("t6_post_rst_edge", tick_log[0] - rel, BASE);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ripple_ctrl.md
Name: ripple_ctrl

Overview:
- Upstream control stage for the 8-bit rippling-LED shifter.
- Synchronises and debounces two raw push-buttons, and holds the ripple direction and speed setting.
- Emits a one-cycle shift_tick at the selected rate; the LED stage shifts once per tick, toward dir.
- Replaces the LED stage's fixed internal SHIFT_TIME divider with a run-time-controllable rate.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a button must differ from its debounced state before that state changes; minimum 1.
- BASE_PERIOD, 5: shift period in clk cycles at speed_sel=0; minimum 2.
- CNT_W, 8: tick counter width; must hold BASE_PERIOD*8-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_dir  input  1  raw asynchronous direction button, active-high.
- btn_speed  input  1  raw asynchronous speed button, active-high.
- run  input  1  1 = tick generator advances; 0 = freeze.
- shift_tick  output  1  registered one-cycle pulse; LED stage shifts on it.
- dir  output  1  0 = ripple left (toward bit 7), 1 = ripple right.
- speed_sel  output  2  current speed index; period = BASE_PERIOD << speed_sel.

Behaviour:
- Reset (sampled at a rising edge) clears everything to 0:
  - shift_tick, dir, speed_sel, tick counter
  - synchroniser flops, debounce counters, debounced states, edge-detect flops
- Reset has priority over every other event in the same cycle.
- Synchroniser: two flops per button (s1, s2); no logic between them.
- Debounce, per button, each edge:
  - If s2 == db, the counter is cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1, db <= s2 and the counter clears.
  - Else the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes db.
- Press detect: press = db & ~db_q, where db_q is db delayed one cycle.
  - Press is high for exactly one cycle per debounced rising edge.
  - Release (falling edge) has no effect.
- Latency: raw button first sampled high at edge 0 and held:
  - db rises at edge DEBOUNCE_CYCLES+1.
  - dir/speed_sel update at edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- dir toggles on each dir press.
- speed_sel increments on each speed press and wraps 3 -> 0.
- Simultaneous dir and speed presses are both applied on the same edge.
- Tick generator: period P = BASE_PERIOD << speed_sel, computed at CNT_W bits.
  - run=1 and count == P-1: count <= 0, shift_tick <= 1.
  - run=1 otherwise: count increments, shift_tick <= 0.
  - run=0: count holds, shift_tick <= 0. Resuming continues from the held count.
- Speed press: count <= 0 and shift_tick <= 0 on that edge, even if the count had reached P-1. The first tick at the new rate follows P_new edges later.
- Dir press does not disturb the tick counter.
- Steady state with run=1: exactly one tick every P cycles, pulse width 1 cycle.
- Reset mid-operation: returns to dir=0, speed_sel=0 and count=0 at that edge. No tick is emitted on the reset edge. A button held through reset must be re-debounced from 0 before it can generate a press.

Test Plan:
- Reset, then run=1 for 30 cycles, buttons low:
  - shift_tick high on the edges 5, 10, 15, 20, 25 after reset release, 1 cycle wide.
  - dir=0, speed_sel=0 throughout.
- btn_dir high for 10 cycles from edge 0 (default params):
  - dir goes 0 -> 1 at edge 6.
  - Second identical press returns dir to 0.
  - Tick spacing unchanged at 5.
- btn_dir bounce (high 2 cycles, low 1 cycle, high 2 cycles, low):
  - dir stays 0.
  - btn_dir then held 6 cycles -> exactly one toggle.
- Four clean speed presses, 20-cycle settle gaps:
  - speed_sel steps 1, 2, 3, 0.
  - Tick periods measured 10, 20, 40, 5.
  - Counter restarts at each press, with no tick on the press edge.
- run=0 asserted at count 3 of a period-5 sequence, held 7 cycles, then run=1:
  - No ticks while frozen.
  - Next tick 2 edges after resume.
- Simultaneous dir+speed press, then reset asserted 2 cycles mid-period:
  - Both dir and speed_sel update on the same edge.
  - After reset: dir=0, speed_sel=0, shift_tick=0.
  - Next tick 5 edges after reset release.
